// File: rtl/fetch_prefetch_unit_if.sv
// Bundle of the fetch unit's instruction-memory, redirect and decode-side signals.
// master = fetch unit, slave = environment (imem, branch unit, decode stage).
interface fetch_prefetch_unit_if #(
  parameter int XLEN = 32
) ();
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            de_valid;
  logic            de_ready;
  logic [31:0]     de_instr;
  logic [XLEN-1:0] de_pc;

  modport master (
    output imem_req, imem_addr, de_valid, de_instr, de_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, de_ready
  );

  modport slave (
    input  imem_req, imem_addr, de_valid, de_instr, de_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, de_ready
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch with credit-limited in-order prefetch queue and redirect flush.
// In-flight responses older than a redirect are counted in discard_reg and dropped.
module fetch_prefetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  parameter int              DEPTH    = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  fetch_prefetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [XLEN-1:0] fetch_pc_reg;
  logic [XLEN-1:0] resp_pc_reg;
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   outstanding_reg;
  logic [CW-1:0]   discard_reg;

  logic [31:0]     q_instr [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];

  logic [CW:0]     credit_used;
  logic            req;
  logic            grant;
  logic            push;
  logic            pop;
  logic            de_valid;
  logic [XLEN-1:0] redirect_aligned;
  logic [CW-1:0]   rvalid_dec;

  // Queued words plus in-flight requests must fit, so every response has a slot.
  assign credit_used      = {1'b0, count_reg} + {1'b0, outstanding_reg};
  assign req              = rst_n && !bus.redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign grant            = req && bus.imem_gnt;
  assign push             = bus.imem_rvalid && (discard_reg == '0);
  assign de_valid         = (count_reg != '0);
  assign pop              = de_valid && bus.de_ready;
  assign redirect_aligned = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign rvalid_dec       = CW'(bus.imem_rvalid);

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc_reg;
  assign bus.de_valid  = de_valid;
  assign bus.de_instr  = de_valid ? q_instr[rd_ptr_reg] : NOP;
  assign bus.de_pc     = de_valid ? q_pc[rd_ptr_reg] : '0;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [31:0]     instr_reg;
      logic [XLEN-1:0] pc_reg;

      always_ff @(posedge clk) begin
        if (push && !bus.redirect_valid && (wr_ptr_reg == PW'(gi))) begin
          instr_reg <= bus.imem_rdata;
          pc_reg    <= resp_pc_reg;
        end
      end

      assign q_instr[gi] = instr_reg;
      assign q_pc[gi]    = pc_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_reg    <= PC_RESET;
      resp_pc_reg     <= PC_RESET;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else if (bus.redirect_valid) begin
      // Every request still in flight predates the new PC, so all of it is dropped.
      fetch_pc_reg    <= redirect_aligned;
      resp_pc_reg     <= redirect_aligned;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      outstanding_reg <= outstanding_reg - rvalid_dec;
      discard_reg     <= outstanding_reg - rvalid_dec;
    end else begin
      if (grant) begin
        fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
      end
      if (push) begin
        resp_pc_reg <= resp_pc_reg + XLEN'(4);
        wr_ptr_reg  <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg       <= count_reg + CW'(push) - CW'(pop);
      outstanding_reg <= outstanding_reg + CW'(grant) - rvalid_dec;
      if (bus.imem_rvalid && (discard_reg != '0)) begin
        discard_reg <= discard_reg - CW'(1);
      end
    end
  end
endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline.
- Issues in-order word fetches to the instruction memory over a req/gnt/rvalid interface, which allows variable response latency.
- Buffers returned words with their PCs in a DEPTH-entry prefetch queue and presents them to the decode pipeline register through a valid/ready handshake.
- Handles control-flow redirects: flushes the queue, discards in-flight responses, and restarts fetch at the new PC.

Parameters:
- XLEN, 32, data/address width.
- PC_RESET, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, number of prefetch queue entries; power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- imem_req  out  1  fetch request valid
- imem_addr  out  XLEN  fetch address, word aligned
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid; responses return in request order
- imem_rdata  in  32  response instruction word
- redirect_valid  in  1  control-flow change (branch/jump taken)
- redirect_pc  in  XLEN  new fetch PC
- de_valid  out  1  queue head valid to decode
- de_ready  in  1  decode accepts head
- de_instr  out  32  head instruction
- de_pc  out  XLEN  head instruction PC

Behaviour:
- Reset state (rst_n=0 at posedge):
  - fetch_pc=PC_RESET, resp_pc=PC_RESET.
  - Queue empty; outstanding=0; discard=0.
  - imem_req=0, de_valid=0, de_instr=32'h0000_0013 (NOP), de_pc=0.
  - Reset mid-transaction abandons all outstanding requests. The memory must be reset alongside; rvalid after reset is not expected.
- Credit rule: imem_req=1 iff occupancy + outstanding < DEPTH and redirect_valid=0. This guarantees the queue never overflows.
- imem_addr = fetch_pc whenever imem_req=1, else don't-care (drive fetch_pc).
- Request stability: once asserted, req and addr hold until gnt. The only exception is a redirect cycle, in which req drops.
- On req && gnt: fetch_pc += 4 (wraps modulo 2^XLEN) and outstanding increments.
- On imem_rvalid: outstanding decrements.
  - If discard>0: discard decrements and the data is dropped.
  - Otherwise {resp_pc, imem_rdata} is pushed at the tail and resp_pc += 4.
- Pop: de_valid && de_ready removes the head at the posedge.
  - Push and pop in the same cycle are both honoured, including when the queue is full or empty.
- No bypass: a word pushed in cycle N is first visible at de_valid in cycle N+1.
  - Minimum latency from reset release with gnt=1 and 1-cycle rvalid: req in cycle 0, rvalid in cycle 1, de_valid in cycle 2.
- de_valid = queue non-empty. de_instr/de_pc come from the head entry when valid; otherwise NOP/0.
- Redirect (redirect_valid=1 at posedge) has priority over every other event in that cycle:
  - Queue is flushed; any pop in that cycle is ignored.
  - fetch_pc and resp_pc are loaded with {redirect_pc[XLEN-1:2], 2'b00}. Misaligned low bits are cleared.
  - discard = outstanding - (imem_rvalid ? 1 : 0) + discard-adjust. The response arriving in the redirect cycle is dropped. Net effect: every response for a pre-redirect request is discarded.
  - imem_req=0 in the redirect cycle. Fetch resumes the following cycle.
- Back-to-back redirects: the last one wins; discard accumulates correctly.
- A redirect while req is pending without gnt abandons that request. It is not counted as outstanding.
- Counters are sized $clog2(DEPTH)+1 bits. outstanding+occupancy never exceeds DEPTH.

Test Plan:
- Reset release, gnt=1 every cycle, rvalid 1 cycle after gnt, de_ready=1:
  - imem_addr sequence is 0,4,8,…
  - de_valid first high in cycle 2 with de_pc=0 and de_instr equal to the word at 0.
  - Thereafter one instruction per cycle with PC increasing by 4.
- de_ready=0 with memory always responding:
  - Exactly 4 grants are issued, then imem_req stays 0.
  - Queue holds PCs 0,4,8,12.
  - On raising de_ready, PCs drain in order and requests resume.
- gnt withheld 3 cycles on addr 0x10:
  - imem_req and imem_addr=0x10 stay stable for all 3 cycles.
  - Single issue on gnt; no duplicate fetch.
- Redirect to 0x200 with 2 requests outstanding and 2 entries queued:
  - Queue empties the next cycle.
  - The 2 late responses are dropped.
  - The next de_pc is 0x200.
- Redirect to 0x103 in the same cycle as an rvalid:
  - The rvalid word is dropped.
  - The next fetch address is 0x100.
- Two redirects on consecutive cycles (to 0x40, then 0x80):
  - Only instructions from 0x80 reach decode.
  - outstanding and discard return to 0 once all responses arrive.
